// File: rtl/flood_pkg.sv
// rtl/flood_pkg.sv - shared state type, field widths and move-budget helper for Flood-It
package flood_pkg;

    typedef enum logic [1:0] {
        SETUP = 2'd0,
        PLAY  = 2'd1,
        WON   = 2'd2,
        LOST  = 2'd3
    } state_t;

    localparam int MAX_TRIES = 99;
    localparam int SIZE_W    = 5;
    localparam int COLOR_W   = 4;
    localparam int TRIES_W   = 8;
    localparam int PROD_W    = 11;

    // Budget = min(99, ((size*colors*3) >> 3) + 1); the shift is the only truncation.
    function automatic logic [TRIES_W-1:0] calc_budget(
        input logic [SIZE_W-1:0]  size,
        input logic [COLOR_W-1:0] colors
    );
        logic [PROD_W-1:0] w_prod;
        logic [PROD_W-1:0] w_budget;
        w_prod   = PROD_W'(size) * PROD_W'(colors) * PROD_W'(3);
        w_budget = (w_prod >> 3) + PROD_W'(1);
        if (w_budget > PROD_W'(MAX_TRIES)) begin
            return TRIES_W'(MAX_TRIES);
        end
        return w_budget[TRIES_W-1:0];
    endfunction

endpackage

// File: rtl/tries_counter.sv
// rtl/tries_counter.sv - saturating move counter with latched budget and next-value limit flag
module tries_counter
    import flood_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic               i_inc,
    input  logic [TRIES_W-1:0] i_limit,
    output logic [TRIES_W-1:0] o_count,
    output logic [TRIES_W-1:0] o_limit,
    output logic               o_at_limit
);

    logic [TRIES_W-1:0] r_count;
    logic [TRIES_W-1:0] r_limit;
    logic [TRIES_W-1:0] w_count_inc;

    assign w_count_inc = (r_count >= TRIES_W'(MAX_TRIES)) ? r_count : r_count + TRIES_W'(1);

    // Flag refers to the value the count would take on this increment.
    assign o_at_limit  = (w_count_inc == r_limit);
    assign o_count     = r_count;
    assign o_limit     = r_limit;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
            r_limit <= '0;
        end else if (i_clr) begin
            r_count <= '0;
            r_limit <= i_limit;
        end else if (i_inc) begin
            r_count <= w_count_inc;
        end
    end

endmodule

// File: rtl/flood_game_ctrl.sv
// rtl/flood_game_ctrl.sv - Flood-It game flow: settings menu, move counting and win/lose state
module flood_game_ctrl
    import flood_pkg::*;
#(
    parameter int SIZE_MIN      = 2,
    parameter int SIZE_MAX      = 14,
    parameter int SIZE_DEFAULT  = 6,
    parameter int COLOR_MIN     = 3,
    parameter int COLOR_MAX     = 8,
    parameter int COLOR_DEFAULT = 4
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               BTN_UP,
    input  logic               BTN_DOWN,
    input  logic               BTN_SEL,
    input  logic               BTN_START,
    input  logic               MOVE_VALID,
    input  logic               BOARD_FULL,
    output logic [SIZE_W-1:0]  SIZE,
    output logic [COLOR_W-1:0] COLOR_NUM,
    output logic               sORc,
    output logic               MODE,
    output logic [TRIES_W-1:0] TRIES,
    output logic [TRIES_W-1:0] TOTAL_TRIES,
    output logic               NEW_GAME,
    output logic               GAME_OVER,
    output logic               WIN
);

    state_t              r_state;
    state_t              w_state_next;
    logic [SIZE_W-1:0]   r_size;
    logic [COLOR_W-1:0]  r_color;
    logic                r_sorc;
    logic                r_new_game;
    logic                w_start_game;
    logic                w_count_move;
    logic                w_at_limit;
    logic                w_step_up;
    logic                w_step_down;
    logic [TRIES_W-1:0]  w_budget;

    assign w_start_game = (r_state == SETUP) && BTN_START;
    assign w_count_move = (r_state == PLAY) && MOVE_VALID && !BTN_START;
    assign w_step_up    = BTN_UP && !BTN_DOWN;
    assign w_step_down  = BTN_DOWN && !BTN_UP;
    assign w_budget     = calc_budget(r_size, r_color);

    tries_counter u_tries (
        .i_clk      (CLOCK),
        .i_rst      (RESET),
        .i_clr      (w_start_game),
        .i_inc      (w_count_move),
        .i_limit    (w_budget),
        .o_count    (TRIES),
        .o_limit    (TOTAL_TRIES),
        .o_at_limit (w_at_limit)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= SETUP;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SETUP: begin
                if (BTN_START) w_state_next = PLAY;
            end
            PLAY: begin
                if (BTN_START) begin
                    w_state_next = SETUP;
                end else if (MOVE_VALID) begin
                    if (BOARD_FULL)      w_state_next = WON;
                    else if (w_at_limit) w_state_next = LOST;
                end
            end
            WON, LOST: begin
                if (BTN_START) w_state_next = SETUP;
            end
            default: w_state_next = SETUP;
        endcase
    end

    // Menu edits only while in SETUP; START in the same cycle wins over SEL/UP/DOWN.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_size     <= SIZE_W'(SIZE_DEFAULT);
            r_color    <= COLOR_W'(COLOR_DEFAULT);
            r_sorc     <= 1'b1;
            r_new_game <= 1'b0;
        end else begin
            r_new_game <= w_start_game;
            if (r_state == SETUP && !BTN_START) begin
                if (BTN_SEL) begin
                    r_sorc <= ~r_sorc;
                end else if (w_step_up) begin
                    if (r_sorc) begin
                        if (r_size < SIZE_W'(SIZE_MAX)) r_size <= r_size + SIZE_W'(1);
                    end else begin
                        if (r_color < COLOR_W'(COLOR_MAX)) r_color <= r_color + COLOR_W'(1);
                    end
                end else if (w_step_down) begin
                    if (r_sorc) begin
                        if (r_size > SIZE_W'(SIZE_MIN)) r_size <= r_size - SIZE_W'(1);
                    end else begin
                        if (r_color > COLOR_W'(COLOR_MIN)) r_color <= r_color - COLOR_W'(1);
                    end
                end
            end
        end
    end

    assign SIZE      = r_size;
    assign COLOR_NUM = r_color;
    assign sORc      = r_sorc;
    assign NEW_GAME  = r_new_game;
    assign MODE      = (r_state != SETUP);
    assign GAME_OVER = (r_state == WON) || (r_state == LOST);
    assign WIN       = (r_state == WON);

endmodule

// File: tb/tb_flood_game_ctrl.sv
// tb/tb_flood_game_ctrl.sv - randomized and directed bench for flood_game_ctrl against a game-rule model
module tb_flood_game_ctrl;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic       BTN_UP = 1'b0;
    logic       BTN_DOWN = 1'b0;
    logic       BTN_SEL = 1'b0;
    logic       BTN_START = 1'b0;
    logic       MOVE_VALID = 1'b0;
    logic       BOARD_FULL = 1'b0;
    logic [4:0] SIZE;
    logic [3:0] COLOR_NUM;
    logic       sORc;
    logic       MODE;
    logic [7:0] TRIES;
    logic [7:0] TOTAL_TRIES;
    logic       NEW_GAME;
    logic       GAME_OVER;
    logic       WIN;

    flood_game_ctrl dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .BTN_UP      (BTN_UP),
        .BTN_DOWN    (BTN_DOWN),
        .BTN_SEL     (BTN_SEL),
        .BTN_START   (BTN_START),
        .MOVE_VALID  (MOVE_VALID),
        .BOARD_FULL  (BOARD_FULL),
        .SIZE        (SIZE),
        .COLOR_NUM   (COLOR_NUM),
        .sORc        (sORc),
        .MODE        (MODE),
        .TRIES       (TRIES),
        .TOTAL_TRIES (TOTAL_TRIES),
        .NEW_GAME    (NEW_GAME),
        .GAME_OVER   (GAME_OVER),
        .WIN         (WIN)
    );

    always #5 CLOCK = ~CLOCK;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Game model: phase 0 = setup, 1 = playing, 2 = won, 3 = lost.
    int m_phase, m_size, m_color, m_sorc, m_tries, m_total, m_new;

    function automatic int budget(input int s, input int c);
        int b;
        b = (s * c * 3) / 8 + 1;
        return (b > 99) ? 99 : b;
    endfunction

    task automatic model_edge(input bit rst, up, dn, sel, st, mv, full);
        m_new = 0;
        if (rst) begin
            m_phase = 0; m_size = 6; m_color = 4; m_sorc = 1;
            m_tries = 0; m_total = 0;
            return;
        end
        case (m_phase)
            0: begin
                if (st) begin
                    m_total = budget(m_size, m_color);
                    m_tries = 0;
                    m_new   = 1;
                    m_phase = 1;
                end else if (sel) begin
                    m_sorc = 1 - m_sorc;
                end else if (up != dn) begin
                    if (m_sorc == 1) m_size  = up ? ((m_size  < 14) ? m_size  + 1 : 14) : ((m_size  > 2) ? m_size  - 1 : 2);
                    else             m_color = up ? ((m_color < 8)  ? m_color + 1 : 8)  : ((m_color > 3) ? m_color - 1 : 3);
                end
            end
            1: begin
                if (st) begin
                    m_phase = 0;
                end else if (mv) begin
                    m_tries = (m_tries < 99) ? m_tries + 1 : 99;
                    if (full)                  m_phase = 2;
                    else if (m_tries == m_total) m_phase = 3;
                end
            end
            default: if (st) m_phase = 0;
        endcase
    endtask

    task automatic step(input bit rst, up, dn, sel, st, mv, full);
        RESET = rst; BTN_UP = up; BTN_DOWN = dn; BTN_SEL = sel;
        BTN_START = st; MOVE_VALID = mv; BOARD_FULL = full;
        @(posedge CLOCK);
        model_edge(rst, up, dn, sel, st, mv, full);
        #1;
        RESET = 0; BTN_UP = 0; BTN_DOWN = 0; BTN_SEL = 0;
        BTN_START = 0; MOVE_VALID = 0; BOARD_FULL = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic lit(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge CLOCK) begin
        if (chk_en) begin
            n_vec++;
            cmp("SIZE",        int'(SIZE),        m_size);
            cmp("COLOR_NUM",   int'(COLOR_NUM),   m_color);
            cmp("sORc",        int'(sORc),        m_sorc);
            cmp("MODE",        int'(MODE),        (m_phase != 0) ? 1 : 0);
            cmp("TRIES",       int'(TRIES),       m_tries);
            cmp("TOTAL_TRIES", int'(TOTAL_TRIES), m_total);
            cmp("NEW_GAME",    int'(NEW_GAME),    m_new);
            cmp("GAME_OVER",   int'(GAME_OVER),   (m_phase >= 2) ? 1 : 0);
            cmp("WIN",         int'(WIN),         (m_phase == 2) ? 1 : 0);
        end
    end

    task automatic check_reset_values(input string tag);
        lit({tag, "_size"},  int'(SIZE), 6);
        lit({tag, "_color"}, int'(COLOR_NUM), 4);
        lit({tag, "_sorc"},  int'(sORc), 1);
        lit({tag, "_mode"},  int'(MODE), 0);
        lit({tag, "_tries"}, int'(TRIES), 0);
        lit({tag, "_total"}, int'(TOTAL_TRIES), 0);
        lit({tag, "_flags"}, int'({NEW_GAME, GAME_OVER, WIN}), 0);
    endtask

    initial begin
        repeat (2) @(posedge CLOCK);
        step(1, 0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        check_reset_values("reset");

        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0, 0);
        lit("size_sat_max", int'(SIZE), 14);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        lit("color_down", int'(COLOR_NUM), 3);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0, 0);
        lit("color_sat_max", int'(COLOR_NUM), 8);
        step(0, 1, 1, 0, 0, 0, 0);
        lit("updown_nochange", int'(COLOR_NUM), 8);

        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        lit("start_new_game", int'(NEW_GAME), 1);
        lit("start_mode", int'(MODE), 1);
        lit("budget_14x6", int'(TOTAL_TRIES), 32);
        lit("start_tries", int'(TRIES), 0);
        idle(1);
        lit("new_game_one_cycle", int'(NEW_GAME), 0);
        step(0, 0, 0, 0, 1, 0, 0);

        step(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        lit("budget_2x3", int'(TOTAL_TRIES), 3);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        lit("two_moves", int'(TRIES), 2);
        lit("two_moves_over", int'(GAME_OVER), 0);
        step(0, 0, 0, 0, 0, 1, 1);
        lit("won_tries", int'(TRIES), 3);
        lit("won_win", int'(WIN), 1);
        step(0, 0, 0, 0, 1, 0, 0);

        step(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);
        lit("lost_over", int'(GAME_OVER), 1);
        lit("lost_win", int'(WIN), 0);
        step(0, 0, 0, 0, 0, 1, 0);
        lit("lost_tries_hold", int'(TRIES), 3);
        step(0, 0, 0, 0, 1, 0, 0);
        lit("back_setup_mode", int'(MODE), 0);
        lit("kept_size", int'(SIZE), 2);
        lit("kept_color", int'(COLOR_NUM), 3);

        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        lit("budget_2x8", int'(TOTAL_TRIES), 7);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        lit("abort_mode", int'(MODE), 0);
        lit("abort_tries", int'(TRIES), 5);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check_reset_values("midgame_reset");

        for (int i = 0; i < 5000; i++) begin
            step(($urandom % 400) == 0,
                 ($urandom % 4) == 0,
                 ($urandom % 4) == 0,
                 ($urandom % 8) == 0,
                 ($urandom % 24) == 0,
                 ($urandom % 3) != 0,
                 ($urandom % 30) == 0);
        end

        @(negedge CLOCK);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
